// File: rtl/ahb_mux_pkg.sv
// Shared constants and types for the AHB-Lite slave response multiplexer.
package ahb_mux_pkg;

  localparam int         NUM_SLV      = 10;
  localparam logic [3:0] MUX_SEL_DFLT = 4'hF;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  typedef enum logic [1:0] {
    OKAY = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } resp_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default-slave response FSM: produces the two-cycle AHB ERROR response for
// unmapped transfers (err_req) or a forced abort (force_err).
module ahb_default_slave
  import ahb_mux_pkg::*;
(
  input  logic HCLK,
  input  logic HRESETn,
  input  logic HREADY,
  input  logic err_req,
  input  logic force_err,
  output logic dflt_ready,
  output logic dflt_resp,
  output logic dflt_active
);

  resp_state_t r_state;
  logic        r_ready;
  logic        r_resp;
  logic        r_active;

  // Response state machine with registered ready/resp/active outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= OKAY;
      r_ready  <= 1'b1;
      r_resp   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        OKAY: begin
          if (force_err || (HREADY && err_req)) begin
            r_state  <= ERR1;
            r_ready  <= 1'b0;
            r_resp   <= 1'b1;
            r_active <= 1'b1;
          end else begin
            r_state  <= OKAY;
            r_ready  <= 1'b1;
            r_resp   <= 1'b0;
            r_active <= 1'b0;
          end
        end
        ERR1: begin
          r_state  <= ERR2;
          r_ready  <= 1'b1;
          r_resp   <= 1'b1;
          r_active <= 1'b1;
        end
        ERR2: begin
          // ERR2 completes the transfer, so a new unmapped request restarts the pair.
          if (HREADY && err_req) begin
            r_state  <= ERR1;
            r_ready  <= 1'b0;
            r_resp   <= 1'b1;
            r_active <= 1'b1;
          end else begin
            r_state  <= OKAY;
            r_ready  <= 1'b1;
            r_resp   <= 1'b0;
            r_active <= 1'b0;
          end
        end
        default: begin
          r_state  <= OKAY;
          r_ready  <= 1'b1;
          r_resp   <= 1'b0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign dflt_ready  = r_ready;
  assign dflt_resp   = r_resp;
  assign dflt_active = r_active;

endmodule

// File: rtl/ahb_slave_mux.sv
// AHB-Lite slave-to-master response mux with integrated default slave.
// Optional stalled-slave timeout enabled by macro AHB_MUX_TIMEOUT_EN.
module ahb_slave_mux
  import ahb_mux_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [3:0]  MUX_SEL,
  input  logic        HSEL_NOMAP,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HRDATA_S0,
  input  logic [31:0] HRDATA_S1,
  input  logic [31:0] HRDATA_S2,
  input  logic [31:0] HRDATA_S3,
  input  logic [31:0] HRDATA_S4,
  input  logic [31:0] HRDATA_S5,
  input  logic [31:0] HRDATA_S6,
  input  logic [31:0] HRDATA_S7,
  input  logic [31:0] HRDATA_S8,
  input  logic [31:0] HRDATA_S9,
  input  logic        HREADYOUT_S0,
  input  logic        HREADYOUT_S1,
  input  logic        HREADYOUT_S2,
  input  logic        HREADYOUT_S3,
  input  logic        HREADYOUT_S4,
  input  logic        HREADYOUT_S5,
  input  logic        HREADYOUT_S6,
  input  logic        HREADYOUT_S7,
  input  logic        HREADYOUT_S8,
  input  logic        HREADYOUT_S9,
  input  logic        HRESP_S0,
  input  logic        HRESP_S1,
  input  logic        HRESP_S2,
  input  logic        HRESP_S3,
  input  logic        HRESP_S4,
  input  logic        HRESP_S5,
  input  logic        HRESP_S6,
  input  logic        HRESP_S7,
  input  logic        HRESP_S8,
  input  logic        HRESP_S9,
  output logic        HREADY,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  logic [3:0]  r_sel_q;
  logic [31:0] w_rdata [16];
  logic [15:0] w_ready;
  logic [15:0] w_resp;
  logic        w_dflt_hit;
  logic        w_err_req;
  logic        w_force_err;
  logic        w_dflt_ready;
  logic        w_dflt_resp;
  logic        w_dflt_active;
  logic        w_unused;

  // Indices 10..15 behave as the zero-wait OKAY default slave.
  assign w_ready = {6'h3F, HREADYOUT_S9, HREADYOUT_S8, HREADYOUT_S7, HREADYOUT_S6,
                    HREADYOUT_S5, HREADYOUT_S4, HREADYOUT_S3, HREADYOUT_S2,
                    HREADYOUT_S1, HREADYOUT_S0};
  assign w_resp  = {6'h00, HRESP_S9, HRESP_S8, HRESP_S7, HRESP_S6, HRESP_S5,
                    HRESP_S4, HRESP_S3, HRESP_S2, HRESP_S1, HRESP_S0};

  assign w_rdata[0] = HRDATA_S0;
  assign w_rdata[1] = HRDATA_S1;
  assign w_rdata[2] = HRDATA_S2;
  assign w_rdata[3] = HRDATA_S3;
  assign w_rdata[4] = HRDATA_S4;
  assign w_rdata[5] = HRDATA_S5;
  assign w_rdata[6] = HRDATA_S6;
  assign w_rdata[7] = HRDATA_S7;
  assign w_rdata[8] = HRDATA_S8;
  assign w_rdata[9] = HRDATA_S9;
  for (genvar g = NUM_SLV; g < 16; g++) begin : g_dflt_data
    assign w_rdata[g] = 32'h0000_0000;
  end

  assign w_dflt_hit = HSEL_NOMAP | (MUX_SEL > 4'd9);
  assign w_err_req  = w_dflt_hit & HTRANS[1];

  ahb_default_slave u_dflt (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HREADY      (HREADY),
    .err_req     (w_err_req),
    .force_err   (w_force_err),
    .dflt_ready  (w_dflt_ready),
    .dflt_resp   (w_dflt_resp),
    .dflt_active (w_dflt_active)
  );

  // Data-phase slave index, captured whenever an address phase is accepted.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sel_q <= MUX_SEL_DFLT;
    end else if (w_force_err) begin
      r_sel_q <= MUX_SEL_DFLT;
    end else if (HREADY) begin
      r_sel_q <= MUX_SEL;
    end else begin
      r_sel_q <= r_sel_q;
    end
  end

  // Response mux: the error FSM overrides whatever slave is selected.
  always_comb begin
    HREADY = w_ready[r_sel_q];
    HRESP  = w_resp[r_sel_q];
    HRDATA = w_rdata[r_sel_q];
    if (w_dflt_active) begin
      HREADY = w_dflt_ready;
      HRESP  = w_dflt_resp;
      HRDATA = 32'h0000_0000;
    end else begin
      HREADY = w_ready[r_sel_q];
      HRESP  = w_resp[r_sel_q];
      HRDATA = w_rdata[r_sel_q];
    end
  end

`ifdef AHB_MUX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall;

  assign w_stall     = ~w_dflt_active & (r_sel_q <= 4'd9) & ~w_ready[r_sel_q];
  // Abort on the cycle that would bring the count to TIMEOUT_CYCLES.
  assign w_force_err = w_stall & (r_stall_cnt == CNT_LAST);
  assign w_unused    = HTRANS[0];

  // Saturating count of consecutive stalled data-phase cycles.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_stall_cnt <= '0;
    end else if (HREADY) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end
`else
  assign w_force_err = 1'b0;
  assign w_unused    = HTRANS[0] ^ (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Self-checking bench for ahb_slave_mux: transfer-level model plus directed
// vectors; honours AHB_MUX_TIMEOUT_EN for the timeout scenario.
module tb_ahb_slave_mux;
  import ahb_mux_pkg::*;

  localparam int TO = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [3:0]  MUX_SEL;
  logic        HSEL_NOMAP;
  logic [1:0]  HTRANS;
  logic [31:0] s_data [10];
  logic        s_rdy  [10];
  logic        s_resp [10];
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  int n_checks = 0;
  int n_errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_slave_mux #(.TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .MUX_SEL(MUX_SEL), .HSEL_NOMAP(HSEL_NOMAP), .HTRANS(HTRANS),
    .HRDATA_S0(s_data[0]), .HRDATA_S1(s_data[1]), .HRDATA_S2(s_data[2]), .HRDATA_S3(s_data[3]),
    .HRDATA_S4(s_data[4]), .HRDATA_S5(s_data[5]), .HRDATA_S6(s_data[6]), .HRDATA_S7(s_data[7]),
    .HRDATA_S8(s_data[8]), .HRDATA_S9(s_data[9]),
    .HREADYOUT_S0(s_rdy[0]), .HREADYOUT_S1(s_rdy[1]), .HREADYOUT_S2(s_rdy[2]), .HREADYOUT_S3(s_rdy[3]),
    .HREADYOUT_S4(s_rdy[4]), .HREADYOUT_S5(s_rdy[5]), .HREADYOUT_S6(s_rdy[6]), .HREADYOUT_S7(s_rdy[7]),
    .HREADYOUT_S8(s_rdy[8]), .HREADYOUT_S9(s_rdy[9]),
    .HRESP_S0(s_resp[0]), .HRESP_S1(s_resp[1]), .HRESP_S2(s_resp[2]), .HRESP_S3(s_resp[3]),
    .HRESP_S4(s_resp[4]), .HRESP_S5(s_resp[5]), .HRESP_S6(s_resp[6]), .HRESP_S7(s_resp[7]),
    .HRESP_S8(s_resp[8]), .HRESP_S9(s_resp[9]),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  // Transfer-level model: which slave owns the data phase, how many error
  // cycles are still owed (0 none, 1 first, 2 second), and stall length.
  int          m_sel;
  int          m_phase;
  int          m_wait;
  logic        exp_ready;
  logic        exp_resp;
  logic [31:0] exp_data;

  always_comb begin
    exp_ready = 1'b1;
    exp_resp  = 1'b0;
    exp_data  = 32'h0;
    if (m_phase == 1) begin
      exp_ready = 1'b0;
      exp_resp  = 1'b1;
    end else if (m_phase == 2) begin
      exp_resp  = 1'b1;
    end else if (m_sel <= 9) begin
      exp_ready = s_rdy[m_sel];
      exp_resp  = s_resp[m_sel];
      exp_data  = s_data[m_sel];
    end
  end

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_sel   <= 15;
      m_phase <= 0;
      m_wait  <= 0;
    end else if (exp_ready) begin
      m_sel   <= int'(MUX_SEL);
      m_phase <= ((HSEL_NOMAP || MUX_SEL > 4'd9) && HTRANS >= HTRANS_NONSEQ) ? 1 : 0;
      m_wait  <= 0;
    end else if (m_phase == 1) begin
      m_phase <= 2;
`ifdef AHB_MUX_TIMEOUT_EN
    end else if (m_phase == 0) begin
      m_wait <= m_wait + 1;
      if (m_wait + 1 == TO) begin
        m_phase <= 1;
        m_sel   <= 15;
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge HCLK) begin
    chk("model_hready", {31'd0, HREADY}, {31'd0, exp_ready});
    chk("model_hresp",  {31'd0, HRESP},  {31'd0, exp_resp});
    chk("model_hrdata", HRDATA, exp_data);
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr(input logic [3:0] sel, input logic nomap, input logic [1:0] tr);
    MUX_SEL    = sel;
    HSEL_NOMAP = nomap;
    HTRANS     = tr;
  endtask

  task automatic expect_out(input string name, input logic rdy, input logic rsp, input logic [31:0] dat);
    @(negedge HCLK);
    chk({name, "_hready"}, {31'd0, HREADY}, {31'd0, rdy});
    chk({name, "_hresp"},  {31'd0, HRESP},  {31'd0, rsp});
    chk({name, "_hrdata"}, HRDATA, dat);
  endtask

  task automatic slaves_default();
    for (int i = 0; i < 10; i++) begin
      s_data[i] = 32'hA000_0000 + 32'(i);
      s_rdy[i]  = 1'b1;
      s_resp[i] = 1'b0;
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    addr(4'hF, 1'b0, HTRANS_IDLE);
    for (int i = 0; i < 10; i++) begin
      s_data[i] = $urandom;
      s_rdy[i]  = 1'($urandom_range(0, 1));
      s_resp[i] = 1'($urandom_range(0, 1));
    end
    expect_out("reset", 1'b1, 1'b0, 32'h0);
    tick();
    HRESETn = 1'b1;
    expect_out("post_reset", 1'b1, 1'b0, 32'h0);
    tick();
    slaves_default();
    expect_out("post_reset2", 1'b1, 1'b0, 32'h0);
    tick();

    // S1 read with two wait states
    addr(4'd1, 1'b0, HTRANS_NONSEQ);
    tick();
    addr(4'hF, 1'b0, HTRANS_IDLE);
    s_data[1] = 32'h1234_5678;
    s_rdy[1]  = 1'b0;
    expect_out("s1_wait1", 1'b0, 1'b0, 32'h1234_5678);
    tick();
    expect_out("s1_wait2", 1'b0, 1'b0, 32'h1234_5678);
    tick();
    s_rdy[1] = 1'b1;
    expect_out("s1_done", 1'b1, 1'b0, 32'h1234_5678);
    tick();

    // Unmapped NONSEQ -> two-cycle ERROR
    addr(4'hF, 1'b1, HTRANS_NONSEQ);
    tick();
    addr(4'hF, 1'b0, HTRANS_IDLE);
    expect_out("nomap_err1", 1'b0, 1'b1, 32'h0);
    tick();
    expect_out("nomap_err2", 1'b1, 1'b1, 32'h0);
    tick();
    expect_out("nomap_okay", 1'b1, 1'b0, 32'h0);
    // Unmapped IDLE -> zero-wait OKAY
    addr(4'hF, 1'b1, HTRANS_IDLE);
    tick();
    addr(4'hF, 1'b0, HTRANS_IDLE);
    expect_out("nomap_idle", 1'b1, 1'b0, 32'h0);
    tick();

    // Pipelined S5 then S2
    addr(4'd5, 1'b0, HTRANS_NONSEQ);
    tick();
    addr(4'd2, 1'b0, HTRANS_NONSEQ);
    s_data[5] = 32'h5555_5555;
    expect_out("pipe_s5", 1'b1, 1'b0, 32'h5555_5555);
    tick();
    addr(4'hF, 1'b0, HTRANS_IDLE);
    expect_out("pipe_s2", 1'b1, 1'b0, 32'hA000_0002);
    tick();

    // Slave ERROR passes through
    addr(4'd3, 1'b0, HTRANS_SEQ);
    tick();
    addr(4'hF, 1'b0, HTRANS_IDLE);
    s_rdy[3] = 1'b0;
    s_resp[3] = 1'b1;
    expect_out("s3_err1", 1'b0, 1'b1, 32'hA000_0003);
    tick();
    s_rdy[3] = 1'b1;
    expect_out("s3_err2", 1'b1, 1'b1, 32'hA000_0003);
    tick();
    s_resp[3] = 1'b0;

    // Unmapped NONSEQ accepted in ERR2 re-enters ERR1
    addr(4'hC, 1'b0, HTRANS_NONSEQ);
    tick();
    expect_out("b2b_err1", 1'b0, 1'b1, 32'h0);
    tick();
    expect_out("b2b_err2", 1'b1, 1'b1, 32'h0);
    tick();
    addr(4'hF, 1'b0, HTRANS_IDLE);
    expect_out("b2b_err1b", 1'b0, 1'b1, 32'h0);
    tick();
    expect_out("b2b_err2b", 1'b1, 1'b1, 32'h0);
    tick();
    expect_out("b2b_okay", 1'b1, 1'b0, 32'h0);

    // Stalled S4
    addr(4'd4, 1'b0, HTRANS_NONSEQ);
    tick();
    addr(4'hF, 1'b0, HTRANS_IDLE);
    s_rdy[4] = 1'b0;
`ifdef AHB_MUX_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      expect_out("to_stall", 1'b0, 1'b0, 32'hA000_0004);
      tick();
    end
    expect_out("to_err1", 1'b0, 1'b1, 32'h0);
    tick();
    s_rdy[4] = 1'b1;
    expect_out("to_err2", 1'b1, 1'b1, 32'h0);
    tick();
    expect_out("to_late", 1'b1, 1'b0, 32'h0);
    tick();
`else
    for (int i = 0; i < 100; i++) begin
      expect_out("stall_hold", 1'b0, 1'b0, 32'hA000_0004);
      tick();
    end
    s_rdy[4] = 1'b1;
    expect_out("stall_release", 1'b1, 1'b0, 32'hA000_0004);
    tick();
`endif

    // Asynchronous reset while in ERR1
    addr(4'hF, 1'b1, HTRANS_NONSEQ);
    tick();
    addr(4'hF, 1'b0, HTRANS_IDLE);
    #1;
    chk("rst_pre_hready", {31'd0, HREADY}, 32'd0);
    HRESETn = 1'b0;
    #1;
    chk("rst_async_hready", {31'd0, HREADY}, 32'd1);
    chk("rst_async_hresp", {31'd0, HRESP}, 32'd0);
    chk("rst_async_hrdata", HRDATA, 32'h0);
    tick();
    HRESETn = 1'b1;
    expect_out("rst_after", 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("rst_after2", 1'b1, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
